axi4_id_echo_restorer: RTL and testbench
========================================

Name: axi4_id_echo_restorer

Overview:
- Sits below the AXI4 ID indexer, in front of an AXI4 slave that carries no user/echo fields.
- On AW/AR it strips the echo bundle (tl_state size/source, extra_id) and stores it in a per-ID FIFO indexed by the 4-bit out ID.
- On B/R it reattaches the stored echo, so the indexer above sees a fully echo-capable slave.
- AW/W/AR/B/R pass through combinationally. The only state is the echo tables and the occupancy counters.

Parameters:
- ID_BITS, 4: width of downstream ID; number of tables = 2^ID_BITS per channel.
- DEPTH, 4: outstanding transactions per ID per direction (power of 2, ≥2).
- ECHO_BITS, 12: stored echo width = {extra_id[1:0], size[3:0], source[5:0]}.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- auto_in_aw_valid/ready  in/out  1  upstream AW handshake.
- auto_in_aw_bits_{id,addr,len,size,burst,lock,cache,prot,qos}  in  4/32/8/3/2/1/4/3/4  AW payload.
- auto_in_aw_bits_echo_{tl_state_size,tl_state_source,extra_id}  in  4/6/2  AW echo, stored.
- auto_in_w_{valid,bits_data,bits_strb,bits_last}/ready  in/out  1,64,8,1/1  W pass-through.
- auto_in_b_valid/ready  out/in  1  B handshake; auto_in_b_bits_{id,resp}  out  4/2.
- auto_in_b_bits_echo_{tl_state_size,tl_state_source,extra_id}  out  4/6/2  restored echo.
- auto_in_ar_* / auto_in_r_*  same shapes as AW/B; R adds data 64 and last 1.
- auto_out_aw_*, auto_out_w_*, auto_out_ar_*  out  mirror of auto_in fields, without any echo.
- auto_out_b_*, auto_out_r_*  in  mirror of response fields, without any echo.

Behaviour:
- Tables: wtab[id] (AW→B) and rtab[id] (AR→R). Each is a DEPTH-entry circular FIFO with wptr, rptr, and a count of width log2(DEPTH)+1.
- AW path, no added latency:
  - auto_out_aw_valid = in_aw_valid & !wfull[id].
  - auto_in_aw_ready = out_aw_ready & !wfull[id].
  - On auto_out_aw fire: push the echo into wtab[aw_id]; wptr += 1 mod DEPTH; count += 1.
- AR path: identical, using rtab.
- W: pure wire pass-through. W is never gated by table state.
- B path:
  - in_b_valid = out_b_valid; out_b_ready = in_b_ready.
  - Echo = head of wtab[b_id], combinational.
  - Pop on fire.
- R path:
  - Echo = head of rtab[r_id], held constant for all beats.
  - Pop only on fire with r_last = 1.
  - Non-last beats leave pointers unchanged.
- Full: count == DEPTH. The request is stalled (valid low downstream, ready low upstream) until a pop on that ID. There is no bypass: push to a full table is blocked even if a pop to the same ID occurs in that cycle.
- Simultaneous push and pop on the same non-full ID: count unchanged, both pointers advance.
- Push and pop on different IDs: independent.
- AW and AR operate fully independently, including identical IDs.
- Reset, asynchronous, active-low:
  - All counts/pointers = 0; stored entries = 0.
  - Combinational outputs follow inputs with tables empty.
  - Reset mid-burst discards all outstanding echo; no recovery is attempted.
- Stall decision depends only on registered count, so there is no combinational loop between valid and ready.

Optional Feature:
- Macro: AXI4_ID_ECHO_RESTORER_CHECK_EN.
- Enabled:
  - Adds output port echo_err (1 bit, registered, sticky, cleared only by reset).
  - Set when a B fire or a last R fire occurs with the corresponding table empty.
  - In that case echo outputs are driven 0 and no pointer/count changes.
- Disabled:
  - No port.
  - Response on an empty table returns whatever entry rptr addresses, and the pointer/count update is suppressed.

Test Plan:
- AW id=3, echo {extra=2, size=3, source=0x15} accepted → later B id=3 returns extra_id=2, size=3, source=0x15; wtab[3] count 1→0.
- Four AWs on id=5 with sources 1,2,3,4, DEPTH=4 → fifth AW: out_aw_valid=0, in_aw_ready=0; B id=5 fires → same cycle still stalled, next cycle fifth accepted; B order returns sources 1,2,3,4.
- AR id=7, source=0x2A, len=3; R beats 0..3 with last on beat 3 → all four beats carry source 0x2A; rtab[7] count drops only after beat 3.
- Same cycle: AW id=1 push and B id=1 pop with count=2 → count stays 2, echo order preserved; AW id=1 and AR id=1 interleaved → tables independent.
- Two outstanding AW, assert reset low mid-stream → counts 0 immediately (asynchronous); after release new AW id=0 echoes correctly.
- With CHECK_EN: B id=9 with empty table → echo outputs 0, echo_err=1 next cycle, stays 1 until reset.

Source files
------------

// File: rtl/axi4_id_echo_restorer.sv
// Strips the AXI4 echo bundle on AW/AR into per-ID FIFOs and reattaches it on B/R.
// Optional macro AXI4_ID_ECHO_RESTORER_CHECK_EN adds a sticky echo_err output for responses on empty tables.
module axi4_id_echo_restorer #(
    parameter int ID_BITS   = 4,
    parameter int DEPTH     = 4,
    parameter int ECHO_BITS = 12
) (
    input  logic               clock,
    input  logic               reset,
    // upstream AW
    input  logic               auto_in_aw_valid,
    output logic               auto_in_aw_ready,
    input  logic [ID_BITS-1:0] auto_in_aw_bits_id,
    input  logic [31:0]        auto_in_aw_bits_addr,
    input  logic [7:0]         auto_in_aw_bits_len,
    input  logic [2:0]         auto_in_aw_bits_size,
    input  logic [1:0]         auto_in_aw_bits_burst,
    input  logic               auto_in_aw_bits_lock,
    input  logic [3:0]         auto_in_aw_bits_cache,
    input  logic [2:0]         auto_in_aw_bits_prot,
    input  logic [3:0]         auto_in_aw_bits_qos,
    input  logic [3:0]         auto_in_aw_bits_echo_tl_state_size,
    input  logic [5:0]         auto_in_aw_bits_echo_tl_state_source,
    input  logic [1:0]         auto_in_aw_bits_echo_extra_id,
    // upstream W
    input  logic               auto_in_w_valid,
    output logic               auto_in_w_ready,
    input  logic [63:0]        auto_in_w_bits_data,
    input  logic [7:0]         auto_in_w_bits_strb,
    input  logic               auto_in_w_bits_last,
    // upstream B
    output logic               auto_in_b_valid,
    input  logic               auto_in_b_ready,
    output logic [ID_BITS-1:0] auto_in_b_bits_id,
    output logic [1:0]         auto_in_b_bits_resp,
    output logic [3:0]         auto_in_b_bits_echo_tl_state_size,
    output logic [5:0]         auto_in_b_bits_echo_tl_state_source,
    output logic [1:0]         auto_in_b_bits_echo_extra_id,
    // upstream AR
    input  logic               auto_in_ar_valid,
    output logic               auto_in_ar_ready,
    input  logic [ID_BITS-1:0] auto_in_ar_bits_id,
    input  logic [31:0]        auto_in_ar_bits_addr,
    input  logic [7:0]         auto_in_ar_bits_len,
    input  logic [2:0]         auto_in_ar_bits_size,
    input  logic [1:0]         auto_in_ar_bits_burst,
    input  logic               auto_in_ar_bits_lock,
    input  logic [3:0]         auto_in_ar_bits_cache,
    input  logic [2:0]         auto_in_ar_bits_prot,
    input  logic [3:0]         auto_in_ar_bits_qos,
    input  logic [3:0]         auto_in_ar_bits_echo_tl_state_size,
    input  logic [5:0]         auto_in_ar_bits_echo_tl_state_source,
    input  logic [1:0]         auto_in_ar_bits_echo_extra_id,
    // upstream R
    output logic               auto_in_r_valid,
    input  logic               auto_in_r_ready,
    output logic [ID_BITS-1:0] auto_in_r_bits_id,
    output logic [63:0]        auto_in_r_bits_data,
    output logic [1:0]         auto_in_r_bits_resp,
    output logic [3:0]         auto_in_r_bits_echo_tl_state_size,
    output logic [5:0]         auto_in_r_bits_echo_tl_state_source,
    output logic [1:0]         auto_in_r_bits_echo_extra_id,
    output logic               auto_in_r_bits_last,
    // downstream AW
    output logic               auto_out_aw_valid,
    input  logic               auto_out_aw_ready,
    output logic [ID_BITS-1:0] auto_out_aw_bits_id,
    output logic [31:0]        auto_out_aw_bits_addr,
    output logic [7:0]         auto_out_aw_bits_len,
    output logic [2:0]         auto_out_aw_bits_size,
    output logic [1:0]         auto_out_aw_bits_burst,
    output logic               auto_out_aw_bits_lock,
    output logic [3:0]         auto_out_aw_bits_cache,
    output logic [2:0]         auto_out_aw_bits_prot,
    output logic [3:0]         auto_out_aw_bits_qos,
    // downstream W
    output logic               auto_out_w_valid,
    input  logic               auto_out_w_ready,
    output logic [63:0]        auto_out_w_bits_data,
    output logic [7:0]         auto_out_w_bits_strb,
    output logic               auto_out_w_bits_last,
    // downstream B
    input  logic               auto_out_b_valid,
    output logic               auto_out_b_ready,
    input  logic [ID_BITS-1:0] auto_out_b_bits_id,
    input  logic [1:0]         auto_out_b_bits_resp,
    // downstream AR
    output logic               auto_out_ar_valid,
    input  logic               auto_out_ar_ready,
    output logic [ID_BITS-1:0] auto_out_ar_bits_id,
    output logic [31:0]        auto_out_ar_bits_addr,
    output logic [7:0]         auto_out_ar_bits_len,
    output logic [2:0]         auto_out_ar_bits_size,
    output logic [1:0]         auto_out_ar_bits_burst,
    output logic               auto_out_ar_bits_lock,
    output logic [3:0]         auto_out_ar_bits_cache,
    output logic [2:0]         auto_out_ar_bits_prot,
    output logic [3:0]         auto_out_ar_bits_qos,
    // downstream R
    input  logic               auto_out_r_valid,
    output logic               auto_out_r_ready,
    input  logic [ID_BITS-1:0] auto_out_r_bits_id,
    input  logic [63:0]        auto_out_r_bits_data,
    input  logic [1:0]         auto_out_r_bits_resp,
    input  logic               auto_out_r_bits_last
`ifdef AXI4_ID_ECHO_RESTORER_CHECK_EN
    ,
    output logic               echo_err
`endif
);

    localparam int NID = 1 << ID_BITS;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    // Handshake rule on every channel: a beat transfers in a cycle where valid and ready
    // are both high; a stalled request drops valid downstream and ready upstream together.

    logic [CW-1:0]        w_cnt  [NID];
    logic [CW-1:0]        r_cnt  [NID];
    logic [ECHO_BITS-1:0] w_head [NID];
    logic [ECHO_BITS-1:0] r_head [NID];

    logic                 aw_full, ar_full, aw_push, ar_push;
    logic                 b_empty, r_empty, b_pop, r_pop;
    logic [ECHO_BITS-1:0] aw_echo, ar_echo, b_echo, r_echo;

    assign aw_echo = {auto_in_aw_bits_echo_extra_id, auto_in_aw_bits_echo_tl_state_size,
                      auto_in_aw_bits_echo_tl_state_source};
    assign ar_echo = {auto_in_ar_bits_echo_extra_id, auto_in_ar_bits_echo_tl_state_size,
                      auto_in_ar_bits_echo_tl_state_source};

    // Stall depends only on the registered count, so valid never loops back to ready.
    assign aw_full = (w_cnt[auto_in_aw_bits_id] == CW'(DEPTH));
    assign ar_full = (r_cnt[auto_in_ar_bits_id] == CW'(DEPTH));
    assign aw_push = auto_in_aw_valid & auto_out_aw_ready & ~aw_full;
    assign ar_push = auto_in_ar_valid & auto_out_ar_ready & ~ar_full;

    assign b_empty = (w_cnt[auto_out_b_bits_id] == '0);
    assign r_empty = (r_cnt[auto_out_r_bits_id] == '0);
    assign b_pop   = auto_out_b_valid & auto_in_b_ready & ~b_empty;
    assign r_pop   = auto_out_r_valid & auto_in_r_ready & auto_out_r_bits_last & ~r_empty;

`ifdef AXI4_ID_ECHO_RESTORER_CHECK_EN
    assign b_echo = b_empty ? '0 : w_head[auto_out_b_bits_id];
    assign r_echo = r_empty ? '0 : r_head[auto_out_r_bits_id];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_err <= 1'b0;
        end else if ((auto_out_b_valid & auto_in_b_ready & b_empty) |
                     (auto_out_r_valid & auto_in_r_ready & auto_out_r_bits_last & r_empty)) begin
            echo_err <= 1'b1;
        end
    end
`else
    assign b_echo = w_head[auto_out_b_bits_id];
    assign r_echo = r_head[auto_out_r_bits_id];
`endif

    for (genvar i = 0; i < NID; i++) begin : g_wtab
        logic [DEPTH-1:0][ECHO_BITS-1:0] mem;
        logic [PW-1:0]                   wp, rp;
        logic [CW-1:0]                   cnt;
        logic                            push, pop;

        assign push = aw_push && (auto_in_aw_bits_id == ID_BITS'(i));
        assign pop  = b_pop && (auto_out_b_bits_id == ID_BITS'(i));

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                mem <= '0;
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push) begin
                    mem[wp] <= aw_echo;
                    wp      <= wp + 1'b1;
                end
                if (pop) rp <= rp + 1'b1;
                if (push && !pop) cnt <= cnt + 1'b1;
                else if (pop && !push) cnt <= cnt - 1'b1;
            end
        end

        assign w_cnt[i]  = cnt;
        assign w_head[i] = mem[rp];
    end

    for (genvar i = 0; i < NID; i++) begin : g_rtab
        logic [DEPTH-1:0][ECHO_BITS-1:0] mem;
        logic [PW-1:0]                   wp, rp;
        logic [CW-1:0]                   cnt;
        logic                            push, pop;

        assign push = ar_push && (auto_in_ar_bits_id == ID_BITS'(i));
        assign pop  = r_pop && (auto_out_r_bits_id == ID_BITS'(i));

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                mem <= '0;
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push) begin
                    mem[wp] <= ar_echo;
                    wp      <= wp + 1'b1;
                end
                if (pop) rp <= rp + 1'b1;
                if (push && !pop) cnt <= cnt + 1'b1;
                else if (pop && !push) cnt <= cnt - 1'b1;
            end
        end

        assign r_cnt[i]  = cnt;
        assign r_head[i] = mem[rp];
    end

    assign auto_out_aw_valid      = auto_in_aw_valid & ~aw_full;
    assign auto_in_aw_ready       = auto_out_aw_ready & ~aw_full;
    assign auto_out_aw_bits_id    = auto_in_aw_bits_id;
    assign auto_out_aw_bits_addr  = auto_in_aw_bits_addr;
    assign auto_out_aw_bits_len   = auto_in_aw_bits_len;
    assign auto_out_aw_bits_size  = auto_in_aw_bits_size;
    assign auto_out_aw_bits_burst = auto_in_aw_bits_burst;
    assign auto_out_aw_bits_lock  = auto_in_aw_bits_lock;
    assign auto_out_aw_bits_cache = auto_in_aw_bits_cache;
    assign auto_out_aw_bits_prot  = auto_in_aw_bits_prot;
    assign auto_out_aw_bits_qos   = auto_in_aw_bits_qos;

    assign auto_out_ar_valid      = auto_in_ar_valid & ~ar_full;
    assign auto_in_ar_ready       = auto_out_ar_ready & ~ar_full;
    assign auto_out_ar_bits_id    = auto_in_ar_bits_id;
    assign auto_out_ar_bits_addr  = auto_in_ar_bits_addr;
    assign auto_out_ar_bits_len   = auto_in_ar_bits_len;
    assign auto_out_ar_bits_size  = auto_in_ar_bits_size;
    assign auto_out_ar_bits_burst = auto_in_ar_bits_burst;
    assign auto_out_ar_bits_lock  = auto_in_ar_bits_lock;
    assign auto_out_ar_bits_cache = auto_in_ar_bits_cache;
    assign auto_out_ar_bits_prot  = auto_in_ar_bits_prot;
    assign auto_out_ar_bits_qos   = auto_in_ar_bits_qos;

    assign auto_out_w_valid     = auto_in_w_valid;
    assign auto_in_w_ready      = auto_out_w_ready;
    assign auto_out_w_bits_data = auto_in_w_bits_data;
    assign auto_out_w_bits_strb = auto_in_w_bits_strb;
    assign auto_out_w_bits_last = auto_in_w_bits_last;

    assign auto_in_b_valid   = auto_out_b_valid;
    assign auto_out_b_ready  = auto_in_b_ready;
    assign auto_in_b_bits_id = auto_out_b_bits_id;
    assign auto_in_b_bits_resp = auto_out_b_bits_resp;
    assign {auto_in_b_bits_echo_extra_id, auto_in_b_bits_echo_tl_state_size,
            auto_in_b_bits_echo_tl_state_source} = b_echo;

    assign auto_in_r_valid     = auto_out_r_valid;
    assign auto_out_r_ready    = auto_in_r_ready;
    assign auto_in_r_bits_id   = auto_out_r_bits_id;
    assign auto_in_r_bits_data = auto_out_r_bits_data;
    assign auto_in_r_bits_resp = auto_out_r_bits_resp;
    assign auto_in_r_bits_last = auto_out_r_bits_last;
    assign {auto_in_r_bits_echo_extra_id, auto_in_r_bits_echo_tl_state_size,
            auto_in_r_bits_echo_tl_state_source} = r_echo;

endmodule

// File: tb/tb_axi4_id_echo_restorer.sv
// Bench for axi4_id_echo_restorer: echo scoreboards per direction, full stall, bursts, resets.
module tb_axi4_id_echo_restorer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // entries are {id, echo}
    logic [15:0] exp_w_q[$];
    logic [15:0] exp_r_q[$];

    logic        auto_in_aw_valid, auto_in_aw_ready, auto_in_aw_bits_lock;
    logic [3:0]  auto_in_aw_bits_id, auto_in_aw_bits_cache, auto_in_aw_bits_qos;
    logic [31:0] auto_in_aw_bits_addr;
    logic [7:0]  auto_in_aw_bits_len;
    logic [2:0]  auto_in_aw_bits_size, auto_in_aw_bits_prot;
    logic [1:0]  auto_in_aw_bits_burst;
    logic [3:0]  auto_in_aw_bits_echo_tl_state_size;
    logic [5:0]  auto_in_aw_bits_echo_tl_state_source;
    logic [1:0]  auto_in_aw_bits_echo_extra_id;
    logic        auto_in_w_valid, auto_in_w_ready, auto_in_w_bits_last;
    logic [63:0] auto_in_w_bits_data;
    logic [7:0]  auto_in_w_bits_strb;
    logic        auto_in_b_valid, auto_in_b_ready;
    logic [3:0]  auto_in_b_bits_id, auto_in_b_bits_echo_tl_state_size;
    logic [1:0]  auto_in_b_bits_resp, auto_in_b_bits_echo_extra_id;
    logic [5:0]  auto_in_b_bits_echo_tl_state_source;
    logic        auto_in_ar_valid, auto_in_ar_ready, auto_in_ar_bits_lock;
    logic [3:0]  auto_in_ar_bits_id, auto_in_ar_bits_cache, auto_in_ar_bits_qos;
    logic [31:0] auto_in_ar_bits_addr;
    logic [7:0]  auto_in_ar_bits_len;
    logic [2:0]  auto_in_ar_bits_size, auto_in_ar_bits_prot;
    logic [1:0]  auto_in_ar_bits_burst;
    logic [3:0]  auto_in_ar_bits_echo_tl_state_size;
    logic [5:0]  auto_in_ar_bits_echo_tl_state_source;
    logic [1:0]  auto_in_ar_bits_echo_extra_id;
    logic        auto_in_r_valid, auto_in_r_ready, auto_in_r_bits_last;
    logic [3:0]  auto_in_r_bits_id, auto_in_r_bits_echo_tl_state_size;
    logic [63:0] auto_in_r_bits_data;
    logic [1:0]  auto_in_r_bits_resp, auto_in_r_bits_echo_extra_id;
    logic [5:0]  auto_in_r_bits_echo_tl_state_source;
    logic        auto_out_aw_valid, auto_out_aw_ready, auto_out_aw_bits_lock;
    logic [3:0]  auto_out_aw_bits_id, auto_out_aw_bits_cache, auto_out_aw_bits_qos;
    logic [31:0] auto_out_aw_bits_addr;
    logic [7:0]  auto_out_aw_bits_len;
    logic [2:0]  auto_out_aw_bits_size, auto_out_aw_bits_prot;
    logic [1:0]  auto_out_aw_bits_burst;
    logic        auto_out_w_valid, auto_out_w_ready, auto_out_w_bits_last;
    logic [63:0] auto_out_w_bits_data;
    logic [7:0]  auto_out_w_bits_strb;
    logic        auto_out_b_valid, auto_out_b_ready;
    logic [3:0]  auto_out_b_bits_id;
    logic [1:0]  auto_out_b_bits_resp;
    logic        auto_out_ar_valid, auto_out_ar_ready, auto_out_ar_bits_lock;
    logic [3:0]  auto_out_ar_bits_id, auto_out_ar_bits_cache, auto_out_ar_bits_qos;
    logic [31:0] auto_out_ar_bits_addr;
    logic [7:0]  auto_out_ar_bits_len;
    logic [2:0]  auto_out_ar_bits_size, auto_out_ar_bits_prot;
    logic [1:0]  auto_out_ar_bits_burst;
    logic        auto_out_r_valid, auto_out_r_ready, auto_out_r_bits_last;
    logic [3:0]  auto_out_r_bits_id;
    logic [63:0] auto_out_r_bits_data;
    logic [1:0]  auto_out_r_bits_resp;
`ifdef AXI4_ID_ECHO_RESTORER_CHECK_EN
    logic        echo_err;
`endif

    axi4_id_echo_restorer dut (
        .clock(clock), .reset(reset),
        .auto_in_aw_valid(auto_in_aw_valid), .auto_in_aw_ready(auto_in_aw_ready),
        .auto_in_aw_bits_id(auto_in_aw_bits_id), .auto_in_aw_bits_addr(auto_in_aw_bits_addr),
        .auto_in_aw_bits_len(auto_in_aw_bits_len), .auto_in_aw_bits_size(auto_in_aw_bits_size),
        .auto_in_aw_bits_burst(auto_in_aw_bits_burst), .auto_in_aw_bits_lock(auto_in_aw_bits_lock),
        .auto_in_aw_bits_cache(auto_in_aw_bits_cache), .auto_in_aw_bits_prot(auto_in_aw_bits_prot),
        .auto_in_aw_bits_qos(auto_in_aw_bits_qos),
        .auto_in_aw_bits_echo_tl_state_size(auto_in_aw_bits_echo_tl_state_size),
        .auto_in_aw_bits_echo_tl_state_source(auto_in_aw_bits_echo_tl_state_source),
        .auto_in_aw_bits_echo_extra_id(auto_in_aw_bits_echo_extra_id),
        .auto_in_w_valid(auto_in_w_valid), .auto_in_w_ready(auto_in_w_ready),
        .auto_in_w_bits_data(auto_in_w_bits_data), .auto_in_w_bits_strb(auto_in_w_bits_strb),
        .auto_in_w_bits_last(auto_in_w_bits_last),
        .auto_in_b_valid(auto_in_b_valid), .auto_in_b_ready(auto_in_b_ready),
        .auto_in_b_bits_id(auto_in_b_bits_id), .auto_in_b_bits_resp(auto_in_b_bits_resp),
        .auto_in_b_bits_echo_tl_state_size(auto_in_b_bits_echo_tl_state_size),
        .auto_in_b_bits_echo_tl_state_source(auto_in_b_bits_echo_tl_state_source),
        .auto_in_b_bits_echo_extra_id(auto_in_b_bits_echo_extra_id),
        .auto_in_ar_valid(auto_in_ar_valid), .auto_in_ar_ready(auto_in_ar_ready),
        .auto_in_ar_bits_id(auto_in_ar_bits_id), .auto_in_ar_bits_addr(auto_in_ar_bits_addr),
        .auto_in_ar_bits_len(auto_in_ar_bits_len), .auto_in_ar_bits_size(auto_in_ar_bits_size),
        .auto_in_ar_bits_burst(auto_in_ar_bits_burst), .auto_in_ar_bits_lock(auto_in_ar_bits_lock),
        .auto_in_ar_bits_cache(auto_in_ar_bits_cache), .auto_in_ar_bits_prot(auto_in_ar_bits_prot),
        .auto_in_ar_bits_qos(auto_in_ar_bits_qos),
        .auto_in_ar_bits_echo_tl_state_size(auto_in_ar_bits_echo_tl_state_size),
        .auto_in_ar_bits_echo_tl_state_source(auto_in_ar_bits_echo_tl_state_source),
        .auto_in_ar_bits_echo_extra_id(auto_in_ar_bits_echo_extra_id),
        .auto_in_r_valid(auto_in_r_valid), .auto_in_r_ready(auto_in_r_ready),
        .auto_in_r_bits_id(auto_in_r_bits_id), .auto_in_r_bits_data(auto_in_r_bits_data),
        .auto_in_r_bits_resp(auto_in_r_bits_resp),
        .auto_in_r_bits_echo_tl_state_size(auto_in_r_bits_echo_tl_state_size),
        .auto_in_r_bits_echo_tl_state_source(auto_in_r_bits_echo_tl_state_source),
        .auto_in_r_bits_echo_extra_id(auto_in_r_bits_echo_extra_id),
        .auto_in_r_bits_last(auto_in_r_bits_last),
        .auto_out_aw_valid(auto_out_aw_valid), .auto_out_aw_ready(auto_out_aw_ready),
        .auto_out_aw_bits_id(auto_out_aw_bits_id), .auto_out_aw_bits_addr(auto_out_aw_bits_addr),
        .auto_out_aw_bits_len(auto_out_aw_bits_len), .auto_out_aw_bits_size(auto_out_aw_bits_size),
        .auto_out_aw_bits_burst(auto_out_aw_bits_burst), .auto_out_aw_bits_lock(auto_out_aw_bits_lock),
        .auto_out_aw_bits_cache(auto_out_aw_bits_cache), .auto_out_aw_bits_prot(auto_out_aw_bits_prot),
        .auto_out_aw_bits_qos(auto_out_aw_bits_qos),
        .auto_out_w_valid(auto_out_w_valid), .auto_out_w_ready(auto_out_w_ready),
        .auto_out_w_bits_data(auto_out_w_bits_data), .auto_out_w_bits_strb(auto_out_w_bits_strb),
        .auto_out_w_bits_last(auto_out_w_bits_last),
        .auto_out_b_valid(auto_out_b_valid), .auto_out_b_ready(auto_out_b_ready),
        .auto_out_b_bits_id(auto_out_b_bits_id), .auto_out_b_bits_resp(auto_out_b_bits_resp),
        .auto_out_ar_valid(auto_out_ar_valid), .auto_out_ar_ready(auto_out_ar_ready),
        .auto_out_ar_bits_id(auto_out_ar_bits_id), .auto_out_ar_bits_addr(auto_out_ar_bits_addr),
        .auto_out_ar_bits_len(auto_out_ar_bits_len), .auto_out_ar_bits_size(auto_out_ar_bits_size),
        .auto_out_ar_bits_burst(auto_out_ar_bits_burst), .auto_out_ar_bits_lock(auto_out_ar_bits_lock),
        .auto_out_ar_bits_cache(auto_out_ar_bits_cache), .auto_out_ar_bits_prot(auto_out_ar_bits_prot),
        .auto_out_ar_bits_qos(auto_out_ar_bits_qos),
        .auto_out_r_valid(auto_out_r_valid), .auto_out_r_ready(auto_out_r_ready),
        .auto_out_r_bits_id(auto_out_r_bits_id), .auto_out_r_bits_data(auto_out_r_bits_data),
        .auto_out_r_bits_resp(auto_out_r_bits_resp), .auto_out_r_bits_last(auto_out_r_bits_last)
`ifdef AXI4_ID_ECHO_RESTORER_CHECK_EN
        , .echo_err(echo_err)
`endif
    );

    // ---------------- driver tasks ----------------
    task automatic aw_req(input logic [3:0] id, input logic [11:0] echo, input logic acc, input string tag);
        logic [31:0] addr;
        logic [7:0]  len;
        @(negedge clock);
        addr = $urandom;
        len  = 8'($urandom_range(0, 255));
        auto_in_aw_valid = 1'b1; auto_in_aw_bits_id = id; auto_in_aw_bits_addr = addr;
        auto_in_aw_bits_len = len; auto_in_aw_bits_size = 3'($urandom_range(0, 7));
        auto_in_aw_bits_burst = 2'd1; auto_in_aw_bits_qos = 4'($urandom_range(0, 15));
        {auto_in_aw_bits_echo_extra_id, auto_in_aw_bits_echo_tl_state_size,
         auto_in_aw_bits_echo_tl_state_source} = echo;
        auto_out_aw_ready = 1'b1;
        #1;
        checks++;
        if ({auto_out_aw_valid, auto_in_aw_ready} !== {acc, acc}) begin
            errors++;
            $display("FAIL %s aw_handshake: got valid=%b ready=%b, want %b", tag, auto_out_aw_valid, auto_in_aw_ready, acc);
        end
        checks++;
        if ({auto_out_aw_bits_id, auto_out_aw_bits_addr, auto_out_aw_bits_len, auto_out_aw_bits_qos} !==
            {id, addr, len, auto_in_aw_bits_qos}) begin
            errors++;
            $display("FAIL %s aw_payload: got id=%h addr=%h len=%h, want id=%h addr=%h len=%h",
                     tag, auto_out_aw_bits_id, auto_out_aw_bits_addr, auto_out_aw_bits_len, id, addr, len);
        end
        if (acc) exp_w_q.push_back({id, echo});
        @(posedge clock); #1;
        auto_in_aw_valid = 1'b0; auto_out_aw_ready = 1'b0;
    endtask

    task automatic ar_req(input logic [3:0] id, input logic [11:0] echo, input logic acc, input string tag);
        logic [31:0] addr;
        @(negedge clock);
        addr = $urandom;
        auto_in_ar_valid = 1'b1; auto_in_ar_bits_id = id; auto_in_ar_bits_addr = addr;
        auto_in_ar_bits_len = 8'd3; auto_in_ar_bits_burst = 2'd1;
        {auto_in_ar_bits_echo_extra_id, auto_in_ar_bits_echo_tl_state_size,
         auto_in_ar_bits_echo_tl_state_source} = echo;
        auto_out_ar_ready = 1'b1;
        #1;
        checks++;
        if ({auto_out_ar_valid, auto_in_ar_ready} !== {acc, acc}) begin
            errors++;
            $display("FAIL %s ar_handshake: got valid=%b ready=%b, want %b", tag, auto_out_ar_valid, auto_in_ar_ready, acc);
        end
        checks++;
        if ({auto_out_ar_bits_id, auto_out_ar_bits_addr, auto_out_ar_bits_len} !== {id, addr, 8'd3}) begin
            errors++;
            $display("FAIL %s ar_payload: got id=%h addr=%h, want id=%h addr=%h", tag, auto_out_ar_bits_id, auto_out_ar_bits_addr, id, addr);
        end
        if (acc) exp_r_q.push_back({id, echo});
        @(posedge clock); #1;
        auto_in_ar_valid = 1'b0; auto_out_ar_ready = 1'b0;
    endtask

    task automatic b_resp(input logic [3:0] id, input logic empty, input string tag);
        logic [1:0]  resp;
        logic [15:0] exp;
        @(negedge clock);
        resp = 2'($urandom_range(0, 3));
        auto_out_b_valid = 1'b1; auto_out_b_bits_id = id; auto_out_b_bits_resp = resp;
        auto_in_b_ready = 1'b1;
        #1;
        checks++;
        if ({auto_in_b_valid, auto_out_b_ready, auto_in_b_bits_id, auto_in_b_bits_resp} !== {2'b11, id, resp}) begin
            errors++;
            $display("FAIL %s b_pass: got valid=%b ready=%b id=%h resp=%h, want 1 1 %h %h", tag,
                     auto_in_b_valid, auto_out_b_ready, auto_in_b_bits_id, auto_in_b_bits_resp, id, resp);
        end
        if (empty) exp = {id, 12'h000};
        else if (exp_w_q.size() == 0) exp = 'x;
        else exp = exp_w_q.pop_front();
        checks++;
        if ({id, auto_in_b_bits_echo_extra_id, auto_in_b_bits_echo_tl_state_size,
             auto_in_b_bits_echo_tl_state_source} !== exp) begin
            errors++;
            $display("FAIL %s b_echo: got id/echo=%h_%h, want %h", tag, id,
                     {auto_in_b_bits_echo_extra_id, auto_in_b_bits_echo_tl_state_size, auto_in_b_bits_echo_tl_state_source}, exp);
        end
        @(posedge clock); #1;
        auto_out_b_valid = 1'b0; auto_in_b_ready = 1'b0;
    endtask

    task automatic r_resp(input logic [3:0] id, input logic last, input string tag);
        logic [63:0] data;
        logic [15:0] exp;
        @(negedge clock);
        data = {$urandom, $urandom};
        auto_out_r_valid = 1'b1; auto_out_r_bits_id = id; auto_out_r_bits_data = data;
        auto_out_r_bits_last = last; auto_out_r_bits_resp = 2'd0; auto_in_r_ready = 1'b1;
        #1;
        checks++;
        if ({auto_in_r_valid, auto_out_r_ready, auto_in_r_bits_id, auto_in_r_bits_data, auto_in_r_bits_last} !==
            {2'b11, id, data, last}) begin
            errors++;
            $display("FAIL %s r_pass: got valid=%b id=%h data=%h last=%b, want 1 %h %h %b", tag,
                     auto_in_r_valid, auto_in_r_bits_id, auto_in_r_bits_data, auto_in_r_bits_last, id, data, last);
        end
        if (exp_r_q.size() == 0) exp = 'x;
        else if (last) exp = exp_r_q.pop_front();
        else exp = exp_r_q[0];
        checks++;
        if ({id, auto_in_r_bits_echo_extra_id, auto_in_r_bits_echo_tl_state_size,
             auto_in_r_bits_echo_tl_state_source} !== exp) begin
            errors++;
            $display("FAIL %s r_echo: got id/echo=%h_%h, want %h", tag, id,
                     {auto_in_r_bits_echo_extra_id, auto_in_r_bits_echo_tl_state_size, auto_in_r_bits_echo_tl_state_source}, exp);
        end
        @(posedge clock); #1;
        auto_out_r_valid = 1'b0; auto_in_r_ready = 1'b0; auto_out_r_bits_last = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        auto_in_aw_valid = 1'b1; auto_out_aw_ready = 1'b1; auto_in_aw_bits_id = 4'd6;
        auto_out_b_bits_id = 4'd6;
        #1;
        checks++;
        if ({auto_out_aw_valid, auto_in_aw_ready, auto_in_b_valid} !== 3'b110) begin
            errors++;
            $display("FAIL reset_pass: got aw_valid=%b aw_ready=%b b_valid=%b, want 1 1 0", auto_out_aw_valid, auto_in_aw_ready, auto_in_b_valid);
        end
        checks++;
        if ({auto_in_b_bits_echo_extra_id, auto_in_b_bits_echo_tl_state_size, auto_in_b_bits_echo_tl_state_source} !== 12'h000) begin
            errors++;
            $display("FAIL reset_echo: got %h, want 000", {auto_in_b_bits_echo_extra_id, auto_in_b_bits_echo_tl_state_size, auto_in_b_bits_echo_tl_state_source});
        end
`ifdef AXI4_ID_ECHO_RESTORER_CHECK_EN
        checks++;
        if (echo_err !== 1'b0) begin errors++; $display("FAIL reset_echo_err: got %b, want 0", echo_err); end
`endif
        auto_in_aw_valid = 1'b0; auto_out_aw_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_basic();
        aw_req(4'd3, {2'd2, 4'd3, 6'h15}, 1'b1, "basic");
        b_resp(4'd3, 1'b0, "basic");
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) aw_req(4'd5, {2'd0, 4'd1, 6'(i)}, 1'b1, "full_fill");
        fork
            aw_req(4'd5, {2'd0, 4'd1, 6'd5}, 1'b0, "full_stall_pop_cycle");
            b_resp(4'd5, 1'b0, "full_pop");
        join
        aw_req(4'd5, {2'd0, 4'd1, 6'd5}, 1'b1, "full_after_pop");
        for (int i = 0; i < 4; i++) b_resp(4'd5, 1'b0, "full_drain");
    endtask

    task automatic test_r_burst();
        for (int i = 0; i < 4; i++) ar_req(4'd7, {2'd1, 4'd3, 6'(6'h2A + i)}, 1'b1, "r_fill");
        for (int beat = 0; beat < 4; beat++) begin
            fork
                ar_req(4'd7, {2'd1, 4'd3, 6'h2E}, 1'b0, "r_stall_in_burst");
                r_resp(4'd7, beat == 3, "r_burst");
            join
        end
        ar_req(4'd7, {2'd1, 4'd3, 6'h2E}, 1'b1, "r_after_last");
        for (int i = 0; i < 4; i++) r_resp(4'd7, 1'b1, "r_drain");
    endtask

    task automatic test_simultaneous();
        aw_req(4'd1, 12'h111, 1'b1, "simul_a");
        aw_req(4'd1, 12'h222, 1'b1, "simul_b");
        fork
            aw_req(4'd1, 12'h333, 1'b1, "simul_push");
            b_resp(4'd1, 1'b0, "simul_pop");
        join
        b_resp(4'd1, 1'b0, "simul_order");
        b_resp(4'd1, 1'b0, "simul_order");
    endtask

    task automatic test_interleave();
        fork
            aw_req(4'd1, 12'hABC, 1'b1, "ilv_aw");
            ar_req(4'd1, 12'h5E1, 1'b1, "ilv_ar");
        join
        ar_req(4'd1, 12'h0F0, 1'b1, "ilv_ar2");
        fork
            b_resp(4'd1, 1'b0, "ilv_b");
            r_resp(4'd1, 1'b1, "ilv_r");
        join
        r_resp(4'd1, 1'b1, "ilv_r2");
    endtask

    task automatic test_w_pass();
        logic [63:0] data;
        logic [7:0]  strb;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            data = {$urandom, $urandom}; strb = 8'($urandom_range(0, 255));
            auto_in_w_valid = 1'($urandom_range(0, 1)); auto_in_w_bits_data = data;
            auto_in_w_bits_strb = strb; auto_in_w_bits_last = 1'(i == 3);
            auto_out_w_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({auto_out_w_valid, auto_in_w_ready, auto_out_w_bits_data, auto_out_w_bits_strb, auto_out_w_bits_last} !==
                {auto_in_w_valid, auto_out_w_ready, data, strb, 1'(i == 3)}) begin
                errors++;
                $display("FAIL w_pass: got data=%h strb=%h, want data=%h strb=%h", auto_out_w_bits_data, auto_out_w_bits_strb, data, strb);
            end
        end
        auto_in_w_valid = 1'b0; auto_out_w_ready = 1'b0;
    endtask

    task automatic test_empty_b();
        b_resp(4'd9, 1'b1, "empty_b");
        aw_req(4'd9, 12'h9A5, 1'b1, "empty_then_aw");
        b_resp(4'd9, 1'b0, "empty_then_b");
`ifdef AXI4_ID_ECHO_RESTORER_CHECK_EN
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (echo_err !== 1'b1) begin errors++; $display("FAIL echo_err_sticky: got %b, want 1", echo_err); end
`endif
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) aw_req(4'd2, 12'(12'h700 + i), 1'b1, "mrst_fill");
        aw_req(4'd2, 12'h7FF, 1'b0, "mrst_full");
        @(negedge clock);
        auto_in_aw_valid = 1'b1; auto_out_aw_ready = 1'b1; auto_in_aw_bits_id = 4'd2;
        auto_out_b_bits_id = 4'd2;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({auto_out_aw_valid, auto_in_aw_ready} !== 2'b11) begin
            errors++;
            $display("FAIL mrst_async: got valid=%b ready=%b, want 1 1", auto_out_aw_valid, auto_in_aw_ready);
        end
        checks++;
        if ({auto_in_b_bits_echo_extra_id, auto_in_b_bits_echo_tl_state_size, auto_in_b_bits_echo_tl_state_source} !== 12'h000) begin
            errors++;
            $display("FAIL mrst_echo_cleared: got %h, want 000", {auto_in_b_bits_echo_extra_id, auto_in_b_bits_echo_tl_state_size, auto_in_b_bits_echo_tl_state_source});
        end
`ifdef AXI4_ID_ECHO_RESTORER_CHECK_EN
        checks++;
        if (echo_err !== 1'b0) begin errors++; $display("FAIL mrst_echo_err: got %b, want 0", echo_err); end
`endif
        exp_w_q.delete();
        @(posedge clock);
        @(negedge clock);
        auto_in_aw_valid = 1'b0; auto_out_aw_ready = 1'b0;
        reset = 1'b1;
        aw_req(4'd0, {2'd3, 4'd2, 6'h3C}, 1'b1, "mrst_new");
        b_resp(4'd0, 1'b0, "mrst_new");
        b_resp(4'd2, 1'b1, "mrst_discarded");
    endtask

    initial begin
        auto_in_aw_valid = 0; auto_in_aw_bits_id = 0; auto_in_aw_bits_addr = 0; auto_in_aw_bits_len = 0;
        auto_in_aw_bits_size = 0; auto_in_aw_bits_burst = 0; auto_in_aw_bits_lock = 0; auto_in_aw_bits_cache = 0;
        auto_in_aw_bits_prot = 0; auto_in_aw_bits_qos = 0; auto_in_aw_bits_echo_tl_state_size = 0;
        auto_in_aw_bits_echo_tl_state_source = 0; auto_in_aw_bits_echo_extra_id = 0;
        auto_in_w_valid = 0; auto_in_w_bits_data = 0; auto_in_w_bits_strb = 0; auto_in_w_bits_last = 0;
        auto_in_b_ready = 0;
        auto_in_ar_valid = 0; auto_in_ar_bits_id = 0; auto_in_ar_bits_addr = 0; auto_in_ar_bits_len = 0;
        auto_in_ar_bits_size = 0; auto_in_ar_bits_burst = 0; auto_in_ar_bits_lock = 0; auto_in_ar_bits_cache = 0;
        auto_in_ar_bits_prot = 0; auto_in_ar_bits_qos = 0; auto_in_ar_bits_echo_tl_state_size = 0;
        auto_in_ar_bits_echo_tl_state_source = 0; auto_in_ar_bits_echo_extra_id = 0;
        auto_in_r_ready = 0;
        auto_out_aw_ready = 0; auto_out_w_ready = 0; auto_out_ar_ready = 0;
        auto_out_b_valid = 0; auto_out_b_bits_id = 0; auto_out_b_bits_resp = 0;
        auto_out_r_valid = 0; auto_out_r_bits_id = 0; auto_out_r_bits_data = 0;
        auto_out_r_bits_resp = 0; auto_out_r_bits_last = 0;

        test_reset();
        test_basic();
        test_full();
        test_r_burst();
        test_simultaneous();
        test_interleave();
        test_w_pass();
        test_empty_b();
        test_mid_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
